// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter with multiplexed 7-segment display.
// Glyphs are active-high gfedcba; DP_BIT selects the decimal point in seg.
package counter_pkg;

  localparam int unsigned DP_BIT = 7;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  function automatic int unsigned ndigits(int unsigned nbits);
    return (nbits + 3) / 4;
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Nibble to 7-segment glyph decoder (gfedcba, active-high).
// Purely combinational; one instance feeds the multiplexed display.
module hex_to_7seg
  import counter_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] glyph_o
);

  always_comb begin
    glyph_o = GLYPH_0;
    unique case (nib_i)
      4'h0: glyph_o = GLYPH_0;
      4'h1: glyph_o = GLYPH_1;
      4'h2: glyph_o = GLYPH_2;
      4'h3: glyph_o = GLYPH_3;
      4'h4: glyph_o = GLYPH_4;
      4'h5: glyph_o = GLYPH_5;
      4'h6: glyph_o = GLYPH_6;
      4'h7: glyph_o = GLYPH_7;
      4'h8: glyph_o = GLYPH_8;
      4'h9: glyph_o = GLYPH_9;
      4'hA: glyph_o = GLYPH_A;
      4'hB: glyph_o = GLYPH_B;
      4'hC: glyph_o = GLYPH_C;
      4'hD: glyph_o = GLYPH_D;
      4'hE: glyph_o = GLYPH_E;
      4'hF: glyph_o = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/updown_counter_7seg.sv
// Modulo up/down counter with load, wrap pulse and scanned hex display.
// Define COUNTER_SATURATE_EN to clamp at the range limits instead of wrapping.
module updown_counter_7seg
  import counter_pkg::*;
#(
  parameter int NBITS    = 8,
  parameter int MODULO   = 2 ** NBITS,
  parameter int SCAN_DIV = 50000
) (
  input  logic                       clk_2,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       down,
  input  logic                       load,
  input  logic [NBITS-1:0]           load_value,
  output logic [NBITS-1:0]           count,
  output logic                       wrap,
  output logic                       sat,
  output logic [7:0]                 seg,
  output logic [(NBITS+3)/4-1:0]     digit_sel
);

  localparam int NDIGITS = (NBITS + 3) / 4;
  localparam int DIW     = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int SW      = $clog2(SCAN_DIV);
  localparam int PW      = 4 * NDIGITS;

  localparam logic [NBITS:0]   MAXV      = (NBITS+1)'(MODULO - 1);
  localparam logic [SW-1:0]    SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DIW-1:0]   DIG_LAST  = DIW'(NDIGITS - 1);

  logic [NBITS-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [SW-1:0]    scan_q, scan_d;
  logic [DIW-1:0]   digit_q, digit_d;

  logic [NBITS:0]   cnt_x;
  logic [NBITS:0]   ld_x;
  logic [NBITS:0]   nxt_x;
  logic             at_top;
  logic             at_bot;
  logic             unused_nxt_hi;

`ifdef COUNTER_SATURATE_EN
  logic             sat_q, sat_d;
`endif

  // One bit of headroom keeps the limit compares exact at full width
  always_comb begin
    cnt_x  = {1'b0, count_q};
    ld_x   = {1'b0, load_value};
    at_top = (cnt_x == MAXV);
    at_bot = (cnt_x == '0);
    nxt_x  = cnt_x;
    wrap_d = 1'b0;
`ifdef COUNTER_SATURATE_EN
    sat_d  = 1'b0;
`endif
    if (load) begin
      nxt_x = (ld_x > MAXV) ? MAXV : ld_x;
    end else if (en) begin
`ifdef COUNTER_SATURATE_EN
      if (!down) begin
        sat_d = at_top;
        nxt_x = at_top ? cnt_x : cnt_x + (NBITS+1)'(1);
      end else begin
        sat_d = at_bot;
        nxt_x = at_bot ? cnt_x : cnt_x - (NBITS+1)'(1);
      end
`else
      if (!down) begin
        wrap_d = at_top;
        nxt_x  = at_top ? '0 : cnt_x + (NBITS+1)'(1);
      end else begin
        wrap_d = at_bot;
        nxt_x  = at_bot ? MAXV : cnt_x - (NBITS+1)'(1);
      end
`endif
    end
    count_d = nxt_x[NBITS-1:0];
  end

  assign unused_nxt_hi = nxt_x[NBITS];

  always_comb begin
    scan_d  = scan_q + SW'(1);
    digit_d = digit_q;
    if (scan_q == SCAN_LAST) begin
      scan_d  = '0;
      digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + DIW'(1);
    end
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      scan_q  <= '0;
      digit_q <= '0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      scan_q  <= scan_d;
      digit_q <= digit_d;
    end
  end

`ifdef COUNTER_SATURATE_EN
  always_ff @(posedge clk_2) begin
    if (reset) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat = sat_q;
`else
  assign sat = 1'b0;
`endif

  assign count = count_q;
  assign wrap  = wrap_q;

  logic [PW-1:0] pad;
  logic [3:0]    nib;
  logic [6:0]    glyph;

  assign pad = PW'(count_q);

  always_comb begin
    nib       = '0;
    digit_sel = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (digit_q == DIW'(i)) begin
        nib          = pad[4*i +: 4];
        digit_sel[i] = 1'b1;
      end
    end
  end

  hex_to_7seg u_hex (
    .nib_i   (nib),
    .glyph_o (glyph)
  );

  always_comb begin
    seg         = {1'b0, glyph};
    seg[DP_BIT] = down && (digit_q == '0);
  end

endmodule

// File: tb/tb_updown_counter_7seg.sv
// Randomized bench for updown_counter_7seg against a behavioural model.
// Two instances share stimulus: full-range (256) and MODULO=10.
module tb_updown_counter_7seg;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       down = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'h00;

  logic [7:0] count_a, count_b;
  logic       wrap_a, wrap_b;
  logic       sat_a, sat_b;
  logic [7:0] seg_a, seg_b;
  logic [1:0] dsel_a, dsel_b;

  always #5 clk_2 = ~clk_2;

  updown_counter_7seg #(.NBITS(8), .MODULO(256), .SCAN_DIV(4)) u_a (
    .clk_2      (clk_2),
    .reset      (reset),
    .en         (en),
    .down       (down),
    .load       (load),
    .load_value (load_value),
    .count      (count_a),
    .wrap       (wrap_a),
    .sat        (sat_a),
    .seg        (seg_a),
    .digit_sel  (dsel_a)
  );

  updown_counter_7seg #(.NBITS(8), .MODULO(10), .SCAN_DIV(4)) u_b (
    .clk_2      (clk_2),
    .reset      (reset),
    .en         (en),
    .down       (down),
    .load       (load),
    .load_value (load_value),
    .count      (count_b),
    .wrap       (wrap_b),
    .sat        (sat_b),
    .seg        (seg_b),
    .digit_sel  (dsel_b)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] GLYPH [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F,
                             8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h77, 8'h7C,
                             8'h39, 8'h5E, 8'h79, 8'h71};

  int mods [2] = '{256, 10};
  int m_c  [2] = '{0, 0};
  int m_w  [2] = '{0, 0};
  int m_s  [2] = '{0, 0};
  int m_scan = 0;
  int m_idx  = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic model_edge();
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_c[k] = 0; m_w[k] = 0; m_s[k] = 0;
      end
      m_scan = 0;
      m_idx  = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        int m;
        bit lim;
        m = mods[k];
        m_w[k] = 0;
        m_s[k] = 0;
        if (load) begin
          m_c[k] = (int'(load_value) >= m) ? m - 1 : int'(load_value);
        end else if (en) begin
          lim = down ? (m_c[k] == 0) : (m_c[k] == m - 1);
`ifdef COUNTER_SATURATE_EN
          m_s[k] = lim;
          if (!lim) m_c[k] = down ? m_c[k] - 1 : m_c[k] + 1;
`else
          m_w[k] = lim;
          m_c[k] = down ? (m_c[k] + m - 1) % m : (m_c[k] + 1) % m;
`endif
        end
      end
      if (m_scan == 3) begin
        m_scan = 0;
        m_idx  = (m_idx + 1) % 2;
      end else begin
        m_scan++;
      end
    end
  endtask

  function automatic logic [7:0] exp_seg(int c);
    logic [7:0] s;
    s = GLYPH[(c >> (4 * m_idx)) & 15];
    if (m_idx == 0 && down) s[7] = 1'b1;
    return s;
  endfunction

  task automatic check_all();
    chk("count_a", 32'(count_a), 32'(m_c[0]));
    chk("wrap_a",  32'(wrap_a),  32'(m_w[0]));
    chk("sat_a",   32'(sat_a),   32'(m_s[0]));
    chk("seg_a",   32'(seg_a),   32'(exp_seg(m_c[0])));
    chk("dsel_a",  32'(dsel_a),  32'(1 << m_idx));
    chk("count_b", 32'(count_b), 32'(m_c[1]));
    chk("wrap_b",  32'(wrap_b),  32'(m_w[1]));
    chk("seg_b",   32'(seg_b),   32'(exp_seg(m_c[1])));
  endtask

  task automatic step(bit r, bit l, logic [7:0] lv, bit e, bit d);
    @(negedge clk_2);
    reset      = r;
    load       = l;
    load_value = lv;
    en         = e;
    down       = d;
    @(posedge clk_2);
    model_edge();
    #1;
    check_all();
  endtask

  logic [7:0] corner [6] = '{8'h00, 8'hFF, 8'h09, 8'h0A, 8'hFE, 8'h01};

  initial begin
    step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    chk("rst_count", 32'(count_a), 32'h00);
    chk("rst_wrap",  32'(wrap_a),  32'h0);
    chk("rst_dsel",  32'(dsel_a),  32'h1);
    chk("rst_seg",   32'(seg_a),   32'h3F);

    step(0, 1, 8'hFE, 0, 0);
    chk("ld_clamp_b", 32'(count_b), 32'h9);
    step(0, 0, 8'h00, 1, 0);
`ifndef COUNTER_SATURATE_EN
    chk("up_ff", 32'(count_a), 32'hFF);
    chk("b_wrap0", 32'(count_b), 32'h0);
    chk("b_wrap1", 32'(wrap_b), 32'h1);
`endif
    step(0, 0, 8'h00, 1, 0);
`ifndef COUNTER_SATURATE_EN
    chk("up_wrap_cnt", 32'(count_a), 32'h00);
    chk("up_wrap_pls", 32'(wrap_a), 32'h1);
`endif
    step(0, 0, 8'h00, 0, 0);
    chk("wrap_one_cyc", 32'(wrap_a), 32'h0);

    step(0, 1, 8'h00, 0, 0);
    step(0, 0, 8'h00, 1, 1);
`ifndef COUNTER_SATURATE_EN
    chk("dn_wrap_cnt", 32'(count_a), 32'hFF);
    chk("dn_wrap_pls", 32'(wrap_a), 32'h1);
`endif

    step(0, 1, 8'hA5, 1, 0);
    chk("ld_over_en", 32'(count_a), 32'hA5);
    for (int i = 0; i < 6; i++) step(0, 0, 8'h00, 0, 0);

`ifdef COUNTER_SATURATE_EN
    step(0, 1, 8'hFF, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    chk("sat_hold", 32'(count_a), 32'hFF);
    chk("sat_flag", 32'(sat_a), 32'h1);
    chk("sat_nowrap", 32'(wrap_a), 32'h0);
    step(1, 0, 8'h00, 1, 0);
    chk("sat_rst_cnt", 32'(count_a), 32'h00);
    chk("sat_rst_flag", 32'(sat_a), 32'h0);
`endif

    for (int n = 0; n < 3000; n++) begin
      bit r, l, e, d;
      logic [7:0] lv;
      r  = ($urandom_range(0, 63) == 0);
      l  = ($urandom_range(0, 7) == 0);
      e  = ($urandom_range(0, 3) != 0);
      d  = (n / 200) % 2 == 1 ? ($urandom_range(0, 7) != 0)
                              : ($urandom_range(0, 7) == 0);
      lv = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)]
                                       : 8'($urandom);
      step(r, l, lv, e, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/updown_counter_7seg.md
UPDOWN_COUNTER_7SEG -- requirements
Module: updown_counter_7seg

Interface
REQ-001 Parameter NBITS, 8, counter width in bits (4..16).
REQ-002 Parameter MODULO, 2**NBITS, count range 0..MODULO-1 (2..2**NBITS).
REQ-003 Parameter SCAN_DIV, 50000, clk_2 cycles per display digit slot (>=2).
REQ-004 Localparam NDIGITS = ceil(NBITS/4), number of hex digits displayed.
REQ-005 clk_2  input  1  clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 en  input  1  count enable.
REQ-008 down  input  1  direction: 0 = increment, 1 = decrement.
REQ-009 load  input  1  synchronous parallel load request.
REQ-010 load_value  input  NBITS  value to load.
REQ-011 count  output  NBITS  current count, registered.
REQ-012 wrap  output  1  one-cycle pulse when the count wraps.
REQ-013 sat  output  1  saturation flag (constant 0 without COUNTER_SATURATE_EN).
REQ-014 seg  output  8  7-segment pattern of selected digit, bits [6:0]=gfedcba, bit 7=dp, active-high.
REQ-015 digit_sel  output  NDIGITS  one-hot active digit, bit 0 = least-significant nibble.

Function
REQ-016 Priority per edge SHALL be reset > load > en; with en=0 and load=0 count SHALL hold.
REQ-017 load SHALL set count to load_value, or to MODULO-1 if load_value >= MODULO; wrap SHALL be 0 that cycle.
REQ-018 en=1, down=0: count SHALL become count+1, or 0 if count == MODULO-1.
REQ-019 en=1, down=1: count SHALL become count-1, or MODULO-1 if count == 0.
REQ-020 wrap SHALL be 1 in exactly the cycle following an edge on which a wrap transition of REQ-018/019 occurred, 0 otherwise.
REQ-021 Arithmetic SHALL be performed in NBITS+1 bits; no implicit truncation may alter the wrap test.
REQ-022 A scan prescaler SHALL count 0..SCAN_DIV-1; at SCAN_DIV-1 the digit index SHALL advance, NDIGITS-1 wrapping to 0.
REQ-023 digit_sel SHALL be one-hot for the digit index; seg[6:0] SHALL be the glyph of nibble count[4*i+3:4*i] of that digit (upper nibble zero-padded).
REQ-024 Glyphs: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-025 seg[7] (dp) SHALL be 1 only on digit 0 while down=1.
REQ-026 seg and digit_sel SHALL be combinational from registered count and digit index, glitch-consistent within one cycle.

Reset
REQ-027 On reset: count=0, wrap=0, sat=0, prescaler=0, digit index=0 (digit_sel=1, seg=3F with dp per down).
REQ-028 Reset asserted mid-count or mid-scan SHALL override load/en on that edge; counting SHALL resume the cycle after deassertion.

Configuration
REQ-029 Macro COUNTER_SATURATE_EN defined: count SHALL hold at MODULO-1 (up) or 0 (down) instead of wrapping; sat SHALL be 1 while count is held at the limit of the current direction with en=1; wrap SHALL stay 0.
REQ-030 COUNTER_SATURATE_EN undefined: wrap-around behaviour of REQ-018..020; sat tied to 0.

Structure
REQ-031 Package counter_pkg SHALL hold the 16 glyph constants and the dp bit index.
REQ-032 Sub-module hex_to_7seg (4-bit nibble in, 7-bit glyph out) SHALL implement REQ-024; one instance drives seg[6:0].

Verification (NBITS=8, MODULO=256, SCAN_DIV=4 unless stated)
REQ-033 reset=1 two cycles -> count=00, wrap=0, digit_sel=01, seg=3F.
REQ-034 load FE, then en=1 down=0 two cycles -> count FF then 00, wrap=1 for one cycle only.
REQ-035 count=00, en=1 down=1 -> count=FF, wrap pulse, seg[7]=1 on digit 0.
REQ-036 load=1 en=1 load_value=A5 same edge -> count=A5; after 4 cycles digit_sel 01->10; seg 6D then 77.
REQ-037 MODULO=10: from 9 up -> 0 with wrap; load_value=12 -> count=9.
REQ-038 COUNTER_SATURATE_EN defined: count=FF, en=1 up -> stays FF, sat=1, wrap=0; reset mid-run -> count=00, sat=0.
